// File: rtl/dac_readback_pkg.sv
// ---------------------------------------------------------------------------
// dac_readback_pkg : shared types and constants for the DAC readback path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dac_readback_pkg;

   localparam int DEFAULT_WORD_WIDTH = 24;

   localparam logic [DEFAULT_WORD_WIDTH-1:0] NOP_WORD = '0;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      CMD_FRAME  = 3'd1,
      GAP        = 3'd2,
      READ_FRAME = 3'd3,
      DONE       = 3'd4
   } rb_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_frame_shifter.sv
// ---------------------------------------------------------------------------
// spi_frame_shifter : one SPI frame (sclk/sync_n/sdo timing) with sdi capture
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_frame_shifter
   import dac_readback_pkg::*;
#(
   parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
   parameter int SCLK_HALF  = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] word,
   input  logic                  sdi,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] captured,
   output logic                  sclk,
   output logic                  sdo,
   output logic                  sync_n
);

   localparam int BW = $clog2(WORD_WIDTH);
   localparam int HW = $clog2(SCLK_HALF + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_WIDTH - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);

   logic                  active;
   logic [WORD_WIDTH-1:0] shift_reg;
   logic [BW-1:0]         bit_cnt;
   logic [HW-1:0]         half_cnt;
   logic                  phase_end;

   assign phase_end = active && (half_cnt == HALF_LAST);
   // done marks the edge that closes the last low phase of the frame
   assign done      = phase_end && !sclk && (bit_cnt == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         active    <= 1'b0;
         shift_reg <= '0;
         captured  <= '0;
         bit_cnt   <= '0;
         half_cnt  <= '0;
         sclk      <= 1'b1;
         sdo       <= 1'b0;
         sync_n    <= 1'b1;
      end else if (start) begin
         active    <= 1'b1;
         shift_reg <= word;
         sdo       <= word[WORD_WIDTH-1];
         sclk      <= 1'b1;
         sync_n    <= 1'b0;
         bit_cnt   <= BIT_LAST;
         half_cnt  <= '0;
      end else if (phase_end) begin
         half_cnt <= '0;
         if (sclk) begin
            sclk     <= 1'b0;
            captured <= {captured[WORD_WIDTH-2:0], sdi};
         end else if (bit_cnt == '0) begin
            active <= 1'b0;
            sclk   <= 1'b1;
            sync_n <= 1'b1;
            sdo    <= 1'b0;
         end else begin
            sclk      <= 1'b1;
            bit_cnt   <= bit_cnt - 1'b1;
            shift_reg <= {shift_reg[WORD_WIDTH-2:0], 1'b0};
            sdo       <= shift_reg[WORD_WIDTH-2];
         end
      end else if (active) begin
         half_cnt <= half_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dac_readback_receiver.sv
// ---------------------------------------------------------------------------
// dac_readback_receiver : AD53xx register readback (command frame + read frame)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dac_readback_receiver
   import dac_readback_pkg::*;
#(
   parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
   parameter int SCLK_HALF  = 1,
   parameter int SYNC_GAP   = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start_readback,
   input  logic [WORD_WIDTH-1:0] readback_cmd,
   output logic                  busy,
   output logic [WORD_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  sclk,
   output logic                  sdo,
   output logic                  sync_n,
   input  logic                  sdi
);

   localparam int GW = $clog2(SYNC_GAP + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(SYNC_GAP - 1);

   rb_state_t             state;
   logic [GW-1:0]         gap_cnt;
   logic                  frame_start;
   logic                  frame_done;
   logic [WORD_WIDTH-1:0] frame_word;
   logic [WORD_WIDTH-1:0] captured;

   // The shifter loads on the same edge the FSM leaves IDLE or GAP
   assign frame_start = ((state == IDLE) && start_readback) ||
                        ((state == GAP) && (gap_cnt == GAP_LAST));
   assign frame_word  = (state == IDLE) ? readback_cmd : WORD_WIDTH'(NOP_WORD);

   spi_frame_shifter #(
      .WORD_WIDTH (WORD_WIDTH),
      .SCLK_HALF  (SCLK_HALF)
   ) u_shifter (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (frame_start),
      .word     (frame_word),
      .sdi      (sdi),
      .done     (frame_done),
      .captured (captured),
      .sclk     (sclk),
      .sdo      (sdo),
      .sync_n   (sync_n)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         gap_cnt  <= '0;
         busy     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start_readback) begin
                  state <= CMD_FRAME;
                  busy  <= 1'b1;
               end
            end
            CMD_FRAME: begin
               if (frame_done) begin
                  state   <= GAP;
                  gap_cnt <= '0;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= READ_FRAME;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            READ_FRAME: begin
               if (frame_done) begin
                  state    <= DONE;
                  rx_data  <= captured;
                  rx_valid <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dac_readback_receiver.sv
// ---------------------------------------------------------------------------
// tb_dac_readback_receiver : directed + randomized readback against a DAC model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_dac_readback_receiver;

   localparam int W    = 24;
   localparam int SH_A = 1;
   localparam int G_A  = 2;
   localparam int SH_B = 3;
   localparam int G_B  = 5;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   always #5 clock = ~clock;

   logic         start_a = 1'b0, start_b = 1'b0;
   logic [W-1:0] cmd_a = '0, cmd_b = '0;
   logic         busy_a, rx_valid_a, sclk_a, sdo_a, sync_n_a, sdi_a;
   logic         busy_b, rx_valid_b, sclk_b, sdo_b, sync_n_b, sdi_b;
   logic [W-1:0] rx_data_a, rx_data_b;

   dac_readback_receiver #(.WORD_WIDTH(W), .SCLK_HALF(SH_A), .SYNC_GAP(G_A)) dut_a (
      .clock(clock), .reset_n(reset_n), .start_readback(start_a), .readback_cmd(cmd_a),
      .busy(busy_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .sclk(sclk_a),
      .sdo(sdo_a), .sync_n(sync_n_a), .sdi(sdi_a));

   dac_readback_receiver #(.WORD_WIDTH(W), .SCLK_HALF(SH_B), .SYNC_GAP(G_B)) dut_b (
      .clock(clock), .reset_n(reset_n), .start_readback(start_b), .readback_cmd(cmd_b),
      .busy(busy_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .sclk(sclk_b),
      .sdo(sdo_b), .sync_n(sync_n_b), .sdi(sdi_b));

   // DAC slave models: present reply MSB first, advance on sclk rise, record SDIN on sclk fall
   logic [W-1:0] reply_a = '0, reply_b = '0;
   int           idx_a = 0, idx_b = 0;
   bit           in_frame_a = 0, in_frame_b = 0;
   logic         mosi_a[$];
   logic         mosi_b[$];

   assign sdi_a = reply_a[idx_a];
   assign sdi_b = reply_b[idx_b];

   always @(negedge sync_n_a or posedge sclk_a) begin
      if (!sync_n_a) begin
         if (!in_frame_a) begin in_frame_a = 1; idx_a = W - 1; end
         else if (idx_a > 0) idx_a = idx_a - 1;
      end else in_frame_a = 0;
   end
   always @(negedge sync_n_b or posedge sclk_b) begin
      if (!sync_n_b) begin
         if (!in_frame_b) begin in_frame_b = 1; idx_b = W - 1; end
         else if (idx_b > 0) idx_b = idx_b - 1;
      end else in_frame_b = 0;
   end
   always @(negedge sclk_a) if (!sync_n_a) mosi_a.push_back(sdo_a);
   always @(negedge sclk_b) if (!sync_n_b) mosi_b.push_back(sdo_b);

   int           vectors = 0;
   int           miscompares = 0;
   logic [W-1:0] last_a = '0, last_b = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input bit sel, input logic [W-1:0] cmd, input logic [W-1:0] reply,
                          input int inject_k, input string tag);
      int sh, g, flen, f2, lat, base, j;
      int first_bad, valid_cnt, valid_k, busy_low_k, hold_err;
      logic in1, in2, e_sync, e_sclk, e_sdo;
      logic s_sync, s_sclk, s_sdo, s_busy, s_valid;
      logic [W-1:0] s_data, last, got;
      sh   = sel ? SH_B : SH_A;
      g    = sel ? G_B : G_A;
      flen = 2 * sh * W;
      f2   = flen + g;
      lat  = 2 * flen + g;
      first_bad = -1; valid_cnt = 0; valid_k = -1; busy_low_k = -1; hold_err = 0;
      last = sel ? last_b : last_a;
      if (sel) begin reply_b = reply; base = mosi_b.size(); start_b = 1; cmd_b = cmd; end
      else     begin reply_a = reply; base = mosi_a.size(); start_a = 1; cmd_a = cmd; end
      @(negedge clock);
      if (sel) begin start_b = 0; cmd_b = W'($urandom); end
      else     begin start_a = 0; cmd_a = W'($urandom); end
      for (int k = 0; k <= lat + 20; k++) begin
         s_sync  = sel ? sync_n_b   : sync_n_a;
         s_sclk  = sel ? sclk_b     : sclk_a;
         s_sdo   = sel ? sdo_b      : sdo_a;
         s_busy  = sel ? busy_b     : busy_a;
         s_valid = sel ? rx_valid_b : rx_valid_a;
         s_data  = sel ? rx_data_b  : rx_data_a;
         in1 = (k < flen);
         in2 = (k >= f2) && (k < f2 + flen);
         j = in1 ? k : k - f2;
         e_sync = !(in1 || in2);
         e_sclk = (in1 || in2) ? ((j / sh) % 2 == 0) : 1'b1;
         e_sdo  = 1'b0;
         if (in1) e_sdo = cmd[W - 1 - j / (2 * sh)];
         if (k <= lat && first_bad < 0 &&
             {s_sync, s_sclk, s_sdo, s_busy} !== {e_sync, e_sclk, e_sdo, 1'b1})
            first_bad = k;
         if (s_valid === 1'b1) begin
            valid_cnt++;
            if (valid_k < 0) valid_k = k;
         end
         if (valid_k < 0 && s_data !== last) hold_err++;
         if (s_busy === 1'b0) begin busy_low_k = k; break; end
         if (k == inject_k) begin
            if (sel) begin start_b = 1; cmd_b = '1; end else begin start_a = 1; cmd_a = '1; end
         end else if (k == inject_k + 1) begin
            if (sel) start_b = 0; else start_a = 0;
         end
         @(negedge clock);
      end
      start_a = 0; start_b = 0;
      got = 'x;
      if ((sel ? mosi_b.size() : mosi_a.size()) >= base + W)
         for (int i = 0; i < W; i++) got[W-1-i] = sel ? mosi_b[base+i] : mosi_a[base+i];
      check({tag, " waveform first bad cycle"}, first_bad, -1);
      check({tag, " rx_valid cycle"}, valid_k, lat);
      check({tag, " rx_valid count"}, valid_cnt, 1);
      check({tag, " busy fall cycle"}, busy_low_k, lat + 1);
      check({tag, " frame1 bits at DAC"}, got, cmd);
      check({tag, " rx_data"}, sel ? rx_data_b : rx_data_a, reply);
      check({tag, " rx_data hold before pulse"}, hold_err, 0);
      if (sel) last_b = reply; else last_a = reply;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " a sclk/sync_n/sdo/busy/valid"}, {sclk_a, sync_n_a, sdo_a, busy_a, rx_valid_a}, 5'b11000);
      check({tag, " a rx_data"}, rx_data_a, 0);
      check({tag, " b sclk/sync_n/sdo/busy/valid"}, {sclk_b, sync_n_b, sdo_b, busy_b, rx_valid_b}, 5'b11000);
      check({tag, " b rx_data"}, rx_data_b, 0);
   endtask

   initial begin
      int vcount, inj;
      logic [W-1:0] c, r;

      // reset
      #1 reset_n = 0;
      repeat (3) @(negedge clock);
      check_idle("in reset");
      reset_n = 1;
      @(negedge clock);
      check_idle("after reset");
      repeat (2) @(negedge clock);

      // basic readback then back-to-back start on the cycle busy is first low
      run_txn(0, 24'h9A0000, 24'hA5C3F0, -1, "basic");
      run_txn(0, W'($urandom), 24'h000001, -1, "back2back");

      // start pulse while busy must be ignored
      repeat (3) @(negedge clock);
      run_txn(0, 24'h9A0000, W'($urandom), 10, "start_while_busy");

      // randomized transactions with random idle gaps and ignored starts
      for (int n = 0; n < 6; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clock);
         c   = W'($urandom);
         r   = W'($urandom);
         inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 95)) : -1;
         run_txn(0, c, r, inj, "random");
      end

      // reset during the read frame: outputs idle at once, nothing presented afterwards
      repeat (2) @(negedge clock);
      reply_a = 24'hFFFFFF;
      start_a = 1; cmd_a = 24'h9A0000;
      @(negedge clock);
      start_a = 0;
      repeat (61) @(negedge clock);
      check("pre-reset frame2 sclk/sync_n", {sclk_a, sync_n_a}, 2'b00);
      #1 reset_n = 0;
      #1;
      check("async reset sclk/sync_n/busy", {sclk_a, sync_n_a, busy_a}, 3'b110);
      repeat (3) @(negedge clock);
      reset_n = 1;
      vcount = 0;
      for (int k = 0; k < 120; k++) begin
         @(negedge clock);
         if (rx_valid_a !== 1'b0) vcount++;
      end
      check("post-reset rx_valid count", vcount, 0);
      check_idle("post mid-frame reset");
      last_a = '0;
      last_b = '0;

      // slower sclk and longer gap
      run_txn(1, W'($urandom), 24'h800001, -1, "param_b");
      for (int n = 0; n < 2; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clock);
         run_txn(1, W'($urandom), W'($urandom), -1, "param_b random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
